// File: rtl/data_mem_wait.sv
// -----------------------------------------------------------------------------
// data_mem_wait
//
// Handshaked data memory for a stalling MIPS-style pipeline (MEM stage).
// Byte / halfword / word loads and stores with big-endian lane selection,
// sign or zero extension on sub-word loads, and a configurable number of
// wait states between acceptance and response.
//
// Parameters:
//   DEPTH        number of 32-bit words; word index is addr[31:2]
//   WAIT_CYCLES  extra cycles between acceptance and response (0 is legal)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset (memory contents are kept)
//   req          request strobe, accepted when req && ready and the request
//                carries memRead or memWrite
//   memWrite     store request
//   memRead      load request
//   size         00 byte, 01 half, 10 word, 11 reserved (error)
//   unsigned_ld  1 = zero-extend byte/half loads, 0 = sign-extend
//   addr         byte address
//   write_data   store data, right-aligned
//   ready        high only in IDLE
//   valid        one-cycle completion pulse
//   read_data    registered load result, held until the next completion
//   err          qualifies valid: access rejected, memory untouched
//
// Configuration macro:
//   DMEM_ALIGN_CHECK_EN  defined: misaligned half/word accesses complete with
//                        err=1. Undefined: offset bits are forced to natural
//                        alignment and the access proceeds.
// -----------------------------------------------------------------------------
module data_mem_wait #(
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        memWrite,
    input  logic        memRead,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic        ready,
    output logic        valid,
    output logic [31:0] read_data,
    output logic        err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    // Request captured at acceptance; the pipeline may change its inputs after.
    logic [31:0]     a_addr;
    logic [31:0]     a_wdata;
    logic [1:0]      a_size;
    logic            a_uns;
    logic            a_we;
    logic            a_re;

    // NOTE: the array is deliberately left out of reset; a reset must not wipe
    // stored data, and an unreset array maps onto plain RAM.
    logic [31:0]     mem [DEPTH] = '{13: 32'h0000_0003, default: 32'h0};

    // Operand view of the access being served. In IDLE it is the live inputs
    // (needed when WAIT_CYCLES=0, where acceptance and completion share an
    // edge); otherwise it is the captured request.
    logic            in_idle;
    logic [31:0]     op_addr;
    logic [31:0]     op_wdata;
    logic [1:0]      op_size;
    logic            op_uns;
    logic            op_we;
    logic            op_re;

    logic            accept;
    logic            enter_resp;
    logic            misalign;
    logic            op_err;
    logic [1:0]      off;
    logic [1:0]      byte_sh;
    logic [AW-1:0]   widx;
    logic [31:0]     cur_word;
    logic [31:0]     new_word;
    logic [31:0]     wpos;
    logic [3:0]      be;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [31:0]     ld_val;

    // NOTE: every signal assigned in an always_comb gets a default at the top
    // so no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        in_idle  = (state == S_IDLE);
        op_addr  = in_idle ? addr        : a_addr;
        op_wdata = in_idle ? write_data  : a_wdata;
        op_size  = in_idle ? size        : a_size;
        op_uns   = in_idle ? unsigned_ld : a_uns;
        op_we    = in_idle ? memWrite    : a_we;
        op_re    = in_idle ? memRead     : a_re;

        // A strobe carrying neither read nor write is not an access.
        accept     = in_idle && req && (memRead || memWrite);
        enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                     ((state == S_WAIT) && (cnt == '0));

`ifdef DMEM_ALIGN_CHECK_EN
        off      = op_addr[1:0];
        misalign = ((op_size == 2'b01) && op_addr[0]) ||
                   ((op_size == 2'b10) && (op_addr[1:0] != 2'b00));
`else
        // Without the check, drop the offset bits a naturally aligned
        // access of this size would not have.
        off      = op_addr[1:0];
        misalign = 1'b0;
        if (op_size == 2'b01) begin
            off = {op_addr[1], 1'b0};
        end else if (op_size == 2'b10) begin
            off = 2'b00;
        end
`endif

        op_err = (op_we && op_re) ||
                 (op_size == 2'b11) ||
                 ({2'b00, op_addr[31:2]} >= 32'(DEPTH)) ||
                 misalign;

        widx     = op_addr[AW+1:2];
        cur_word = mem[widx];

        // Big-endian lanes: byte offset 0 is bits [31:24]; be[i] covers
        // bits [8i+7:8i], so be[3] is offset 0.
        be   = 4'b0000;
        wpos = op_wdata;
        case (op_size)
            2'b00: begin
                be   = 4'b1000 >> off;
                wpos = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                be   = off[1] ? 4'b0011 : 4'b1100;
                wpos = {2{op_wdata[15:0]}};
            end
            2'b10: begin
                be   = 4'b1111;
                wpos = op_wdata;
            end
            default: be = 4'b0000;
        endcase

        new_word = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                new_word[8*i +: 8] = wpos[8*i +: 8];
            end
        end

        byte_sh = 2'd3 - off;
        lane_b  = cur_word[{byte_sh, 3'b000} +: 8];
        lane_h  = off[1] ? cur_word[15:0] : cur_word[31:16];

        case (op_size)
            2'b00:   ld_val = op_uns ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   ld_val = op_uns ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            2'b10:   ld_val = cur_word;
            default: ld_val = 32'h0;
        endcase
    end

    // Store commits on the edge that enters RESP. Gating with rst_n drops a
    // store whose commit edge coincides with reset.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && op_we && !op_err) begin
            mem[widx] <= new_word;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ready     <= 1'b1;
            valid     <= 1'b0;
            err       <= 1'b0;
            read_data <= 32'h0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;

            if (enter_resp) begin
                valid <= 1'b1;
                err   <= op_err;
                if (op_err) begin
                    read_data <= 32'h0;
                end else if (op_re) begin
                    read_data <= ld_val;
                end
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_addr  <= addr;
                        a_wdata <= write_data;
                        a_size  <= size;
                        a_uns   <= unsigned_ld;
                        a_we    <= memWrite;
                        a_re    <= memRead;
                        ready   <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CW'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/data_mem_wait.md
# data_mem_wait

Parametrised, handshaked successor to the single-cycle MIPS data memory. Supports byte/halfword/word loads and stores with big-endian lane selection and sign/zero extension, plus a configurable wait-state latency for modelling slow memory in front of a stalling pipeline. Sits in the MEM stage: the pipeline issues `req` and holds its stall until `valid`.

## Interface
- `DEPTH`, 128: number of 32-bit words; word index is `addr[31:2]`.
- `WAIT_CYCLES`, 2: extra cycles between acceptance and response; 0 is legal.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  1  request strobe; accepted when `req && ready`.
- `memWrite`  in  1  store request.
- `memRead`  in  1  load request.
- `size`  in  2  00 byte, 01 half, 10 word, 11 reserved (error).
- `unsigned_ld`  in  1  1 = zero-extend byte/half loads, 0 = sign-extend.
- `addr`  in  32  byte address.
- `write_data`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `ready`  out  1  high only in IDLE.
- `valid`  out  1  one-cycle completion pulse.
- `read_data`  out  32  registered load result, held until next completion.
- `err`  out  1  qualifies `valid`; access rejected, memory untouched.

## Operation
- Time-zero initial contents: all words 0 except word 13 (byte addr 0x34) = 32'h3.
- Reset does not clear memory.
- On acceptance, latch `addr`, `write_data`, `size`, `unsigned_ld`, `memWrite` and `memRead`. Inputs may change afterwards.
- `req` with neither `memRead` nor `memWrite` is ignored: no acceptance, `ready` stays 1.
- Error conditions (any one): both `memRead` and `memWrite` set; `size`=11; word index >= DEPTH; misaligned access (see Configuration).
- On error: no write, `read_data` = 0, `err`=1 with `valid`.
- Lane mapping is big-endian:
  - Byte offset 0 maps to [31:24], offset 3 to [7:0].
  - Half with `addr[1]`=0 maps to [31:16], `addr[1]`=1 to [15:0].
- Store: only the selected lanes are written; other bytes of the word are preserved.
- Load: the selected lane is right-aligned, then extended per `unsigned_ld`. Word loads ignore `unsigned_ld`.
- FSM states:
  - IDLE: `ready`=1. Accept goes to WAIT if `WAIT_CYCLES`>0, else to RESP. Counter loads `WAIT_CYCLES`-1.
  - WAIT: counter decrements; at 0, go to RESP.
  - RESP: `valid`=1 for exactly one cycle, then IDLE.
- The memory write and the `read_data` capture both happen on the clock edge that enters RESP.

## Timing
- Acceptance at edge E0. `valid` is high in the cycle after edge E0+`WAIT_CYCLES`.
- `ready` is low for `WAIT_CYCLES`+1 cycles.
- Peak throughput is one access per `WAIT_CYCLES`+2 cycles.
- Reset values: `ready`=1 (state IDLE), `valid`=0, `err`=0, `read_data`=0, counter 0.
- Reset asserted mid-operation: the next edge forces IDLE. A store that has not yet entered RESP is discarded. No `valid` is produced.
- A load of a word stored by the immediately preceding access returns the new data (write committed before the next acceptance).
- `req` held high through RESP is re-accepted in the following IDLE cycle. The pipeline must drop `req` on `valid` if it does not intend a repeat.
- `read_data` is not updated on ignored requests.

## Configuration
- `DMEM_ALIGN_CHECK_EN`:
  - Defined: half with `addr[0]`=1, or word with `addr[1:0]`≠0, completes with `err`=1 and no access.
  - Undefined: offset bits are forced to natural alignment (half ignores `addr[0]`, word ignores `addr[1:0]`) and the access proceeds. `err` comes only from the other conditions.

## Test plan
- Reset, then word load of addr 0x34 with `WAIT_CYCLES`=2 → `ready` low 3 cycles; `valid` 3 cycles after acceptance with `read_data`=32'h3, `err`=0.
- Word store 0xAABBCCDD to 0x40; byte store 0x11 to 0x41; word load 0x40 → 0xAA11CCDD.
- Byte load 0x40 signed → 0xFFFFFFAA; unsigned → 0x000000AA; half load 0x42 signed → 0xFFFFCCDD.
- Word load of 0x42:
  - With `DMEM_ALIGN_CHECK_EN`: `err`=1, `read_data`=0.
  - Without it: returns word at 0x40.
- Address 0x200 (index 128), and both `memRead`/`memWrite` set → `err`=1. A following read of affected words shows no change.
- Store accepted, `rst_n` low during WAIT → no `valid`; later load returns old data. Repeat all tests with `WAIT_CYCLES`=0 (latency 1).
